// File: rtl/hex_scroll_ctrl.sv
// Avalon-MM six-digit seven-segment controller: hex decode, leading-zero blanking, tick-driven scroll and blink.
// Optional blink phase is compiled in when HEX_BLINK_EN is defined.
module hex_scroll_ctrl #(
    parameter int PRESCALE_W = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

`ifdef HEX_BLINK_EN
    localparam logic [3:0] CTRL_MASK = 4'hF;
`else
    localparam logic [3:0] CTRL_MASK = 4'h7;
`endif
    localparam logic [6:0] BLANK = 7'h7F;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [23:0]           data_q;
    logic [3:0]            ctrl_q;
    logic [PRESCALE_W-1:0] rate_q;
    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;
    logic [3:0]            pos_q;
    logic [3:0]            pos_d;
    logic                  phase_q;
    logic                  phase_d;
    logic [6:0]            hex_q [6];
    logic [6:0]            disp_d [6];

    logic       wr;
    logic       wr_data;
    logic       wr_ctrl;
    logic       wr_rate;
    logic [3:0] w_ctrl;
    logic       en;
    logic       scroll;
    logic       lzb;
    logic       scroll_on;
    logic       blink_on;
    logic       busy;
    logic       cnt_hit;
    logic       tick;
    logic       new_scroll_on;
    logic       unused_wd;

    assign wr      = chipselect & ~write_n;
    assign wr_data = wr & (address == 2'd0);
    assign wr_ctrl = wr & (address == 2'd1);
    assign wr_rate = wr & (address == 2'd2);
    assign w_ctrl  = writedata[3:0] & CTRL_MASK;
    assign unused_wd = ^writedata;

    assign en        = ctrl_q[0];
    assign scroll    = ctrl_q[1];
    assign lzb       = ctrl_q[2];
    assign scroll_on = en & scroll;
    assign blink_on  = en & ctrl_q[3];
    assign busy      = scroll_on | blink_on;
    assign new_scroll_on = w_ctrl[0] & w_ctrl[1];

    // The counter keeps counting through a CTRL write; only POS/PHASE drop that tick.
    assign cnt_hit = busy && (cnt_q == rate_q);
    assign tick    = cnt_hit & ~wr_rate & ~wr_ctrl;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (wr_rate || !busy || cnt_hit) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        pos_d = pos_q;
        if (wr_ctrl) begin
            if (!(new_scroll_on && scroll_on)) begin
                pos_d = 4'd0;
            end
        end else if (tick && scroll_on) begin
            pos_d = (pos_q == 4'd11) ? 4'd0 : pos_q + 4'd1;
        end
    end

`ifdef HEX_BLINK_EN
    logic new_blink_on;
    assign new_blink_on = w_ctrl[0] & w_ctrl[3];

    always_comb begin
        phase_d = phase_q;
        if (wr_ctrl) begin
            if (!(new_blink_on && blink_on)) begin
                phase_d = 1'b0;
            end
        end else if (tick && blink_on) begin
            phase_d = ~phase_q;
        end
    end
`else
    assign phase_d = 1'b0;
`endif

    // Digit pipeline: nibble decode, leading-zero blanking, then the 12-entry scroll ring.
    logic [5:0] lead_zero;
    logic [6:0] shown [6];
    logic [6:0] ring [12];

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_digit
            logic [4:0] sum;
            logic [3:0] idx;

            if (gi == 0) begin : g_lsd
                assign lead_zero[gi] = 1'b0;
            end else begin : g_upper
                assign lead_zero[gi] = (data_q[23:4*gi] == '0);
            end

            assign shown[gi]    = (lzb && lead_zero[gi]) ? BLANK : seg7(data_q[4*gi +: 4]);
            assign ring[gi]     = shown[gi];
            assign ring[gi + 6] = BLANK;

            assign sum = 5'(gi) + {1'b0, pos_q};
            assign idx = (sum >= 5'd12) ? 4'(sum - 5'd12) : sum[3:0];

            assign disp_d[gi] = (!en || phase_q) ? BLANK :
                                scroll           ? ring[idx] :
                                                   shown[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            ctrl_q  <= '0;
            rate_q  <= '0;
            cnt_q   <= '0;
            pos_q   <= '0;
            phase_q <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                hex_q[i] <= BLANK;
            end
        end else begin
            if (wr_data) begin
                data_q <= writedata[23:0];
            end
            if (wr_ctrl) begin
                ctrl_q <= w_ctrl;
            end
            if (wr_rate) begin
                rate_q <= writedata[PRESCALE_W-1:0];
            end
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            phase_q <= phase_d;
            for (int i = 0; i < 6; i++) begin
                hex_q[i] <= disp_d[i];
            end
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0: readdata = {8'd0, data_q};
            2'd1: readdata = {28'd0, ctrl_q};
            2'd2: readdata = 32'(rate_q);
            default: readdata = {26'd0, phase_q, busy, pos_q};
        endcase
    end

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Self-checking bench for hex_scroll_ctrl: directed scenarios plus randomized bus traffic against a behavioural model.
module tb_hex_scroll_ctrl;
    localparam int PW = 24;
`ifdef HEX_BLINK_EN
    localparam logic [31:0] CTRL_MASK = 32'hF;
`else
    localparam logic [31:0] CTRL_MASK = 32'h7;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  addr = 2'd0;
    logic        cs = 1'b0;
    logic        wn = 1'b1;
    logic [31:0] wdata = 32'd0;
    logic [31:0] readdata;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [6:0]  hexv [6];

    int checks = 0;
    int errors = 0;

    hex_scroll_ctrl #(.PRESCALE_W(PW)) dut (
        .clk(clk), .reset_n(reset_n), .address(addr), .chipselect(cs),
        .write_n(wn), .writedata(wdata), .readdata(readdata),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
    );

    assign hexv[0] = hex0;
    assign hexv[1] = hex1;
    assign hexv[2] = hex2;
    assign hexv[3] = hex3;
    assign hexv[4] = hex4;
    assign hexv[5] = hex5;

    always #5 clk = ~clk;

    // Behavioural model state: register contents plus prescaler count, POS and PHASE.
    logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [31:0] m_data, m_ctrl, m_rate, m_cnt, m_pos, m_phase;
    logic [6:0]  m_hex [6];

    function automatic void m_reset();
        m_data = 0; m_ctrl = 0; m_rate = 0; m_cnt = 0; m_pos = 0; m_phase = 0;
        for (int i = 0; i < 6; i++) m_hex[i] = 7'h7F;
    endfunction

    function automatic bit m_en();     return m_ctrl[0]; endfunction
    function automatic bit m_scroll(); return m_ctrl[0] && m_ctrl[1]; endfunction
    function automatic bit m_blink();  return m_ctrl[0] && m_ctrl[3]; endfunction
    function automatic bit m_busy();   return m_scroll() || m_blink(); endfunction

    // What digit i must show for the current model state.
    function automatic logic [6:0] m_digit(int i);
        logic [6:0] shown [6];
        int top, j, nib;
        if (!m_en() || m_phase != 0) return 7'h7F;
        top = 0;
        for (int k = 0; k < 6; k++) if (((m_data >> (4 * k)) & 15) != 0) top = k;
        for (int k = 0; k < 6; k++) begin
            nib = int'((m_data >> (4 * k)) & 15);
            shown[k] = (m_ctrl[2] && k > top) ? 7'h7F : seg_tab[nib];
        end
        if (m_ctrl[1]) begin
            j = (i + int'(m_pos)) % 12;
            return (j < 6) ? shown[j] : 7'h7F;
        end
        return shown[i];
    endfunction

    function automatic logic [31:0] m_read(logic [1:0] a);
        case (a)
            2'd0: return m_data;
            2'd1: return m_ctrl;
            2'd2: return m_rate;
            default: return m_pos | (32'(m_busy()) << 4) | (m_phase << 5);
        endcase
    endfunction

    // One rising edge of the model, using the bus inputs presented to that edge.
    function automatic void m_clock();
        bit wr, hit, was_scroll, was_blink;
        logic [31:0] w;
        wr = cs && !wn;
        was_scroll = m_scroll();
        was_blink = m_blink();
        hit = m_busy() && (m_cnt == m_rate);
        for (int i = 0; i < 6; i++) m_hex[i] = m_digit(i);
        if (wr && addr == 2'd1) begin
            w = wdata & CTRL_MASK;
            if (!(was_scroll && w[0] && w[1])) m_pos = 0;
            if (!(was_blink && w[0] && w[3])) m_phase = 0;
            m_ctrl = w;
        end else if (hit && !(wr && addr == 2'd2)) begin
            if (was_scroll) m_pos = (m_pos + 1) % 12;
            if (was_blink) m_phase = m_phase ^ 1;
        end
        if (wr && addr == 2'd2) m_cnt = 0;
        else m_cnt = (was_scroll || was_blink) && !hit ? m_cnt + 1 : 0;
        if (wr && addr == 2'd0) m_data = wdata & 32'hFF_FFFF;
        if (wr && addr == 2'd2) m_rate = wdata & ((32'd1 << PW) - 1);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock, update the model, then compare every output against it.
    task automatic step();
        @(posedge clk);
        if (reset_n) m_clock();
        #1;
        if (reset_n) begin
            for (int i = 0; i < 6; i++) check($sformatf("hex%0d", i), 32'(hexv[i]), 32'(m_hex[i]));
            check($sformatf("readdata@%0d", addr), readdata, m_read(addr));
        end
    endtask

    task automatic bus_write(logic [1:0] a, logic [31:0] d);
        addr = a; wdata = d; cs = 1'b1; wn = 1'b0;
        step();
        cs = 1'b0; wn = 1'b1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [31:0] rand_word(logic [1:0] a);
        case (a)
            2'd0: return $urandom >> $urandom_range(0, 30);
            2'd1: return ($urandom & 32'hFFFF_FFF0) * $urandom_range(0, 1)
                         | 32'($urandom_range(0, 15)) | 32'($urandom_range(0, 3) != 0);
            2'd2: return 32'($urandom_range(0, 4)) | (32'($urandom_range(0, 1)) << 28);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int k;
        logic [31:0] posb;
        m_reset();
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1 check($sformatf("reset_read%0d", a), readdata, 32'd0);
        end
        for (int i = 0; i < 6; i++) check($sformatf("reset_hex%0d", i), 32'(hexv[i]), 32'h7F);
        reset_n = 1'b1;
        idle(2);

        // Static decode, then leading-zero blanking.
        bus_write(2'd0, 32'h0000_123A);
        bus_write(2'd1, 32'h1);
        step();
        check("static_hex0", 32'(hex0), 32'h08);
        check("static_hex1", 32'(hex1), 32'h30);
        check("static_hex2", 32'(hex2), 32'h24);
        check("static_hex3", 32'(hex3), 32'h79);
        check("static_hex4", 32'(hex4), 32'h40);
        check("static_hex5", 32'(hex5), 32'h40);
        bus_write(2'd1, 32'h5);
        step();
        check("lzb_hex3", 32'(hex3), 32'h79);
        check("lzb_hex4", 32'(hex4), 32'h7F);
        check("lzb_hex5", 32'(hex5), 32'h7F);

        bus_write(2'd0, 32'h0);
        bus_write(2'd1, 32'h5);
        step();
        check("zero_hex0", 32'(hex0), 32'h40);
        check("zero_hex1", 32'(hex1), 32'h7F);
        check("zero_hex5", 32'(hex5), 32'h7F);

        // Scroll with RATE=3: POS advances every 4 cycles and wraps after 11.
        bus_write(2'd2, 32'd3);
        bus_write(2'd0, 32'h0065_4321);
        bus_write(2'd1, 32'h3);
        addr = 2'd3;
        for (int n = 1; n <= 52; n++) begin
            step();
            check("scroll_pos", 32'(readdata[3:0]), 32'((n / 4) % 12));
            if (n == 5) begin
                check("pos1_hex0", 32'(hex0), 32'h24);
                check("pos1_hex4", 32'(hex4), 32'h02);
                check("pos1_hex5", 32'(hex5), 32'h7F);
            end
        end

        // RATE write on the cycle the counter equals the old RATE drops that tick.
        k = 0;
        while (m_cnt != m_rate && k < 12) begin
            step();
            k++;
        end
        check("rate_wait_bound", 32'(m_cnt == m_rate), 32'd1);
        posb = m_pos;
        bus_write(2'd2, 32'd5);
        addr = 2'd3;
        #1 check("rate_wr_no_tick", 32'(readdata[3:0]), posb);
        k = 0;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (readdata[3:0] != posb[3:0]) begin
                k = n;
                break;
            end
        end
        check("rate_wr_next_tick", 32'(k), 32'd6);

`ifdef HEX_BLINK_EN
        // Blink with RATE=1: two cycles decoded, two cycles blank.
        bus_write(2'd1, 32'h0);
        bus_write(2'd2, 32'd1);
        bus_write(2'd1, 32'h9);
        for (int n = 1; n <= 12; n++) begin
            step();
            check("blink_hex0", 32'(hex0), (((n - 1) / 2) % 2 == 1) ? 32'h7F : 32'h79);
        end
        bus_write(2'd1, 32'h1);
        addr = 2'd3;
        for (int n = 1; n <= 6; n++) begin
            step();
            check("unblink_phase", 32'(readdata[5]), 32'd0);
            check("unblink_hex0", 32'(hex0), 32'h79);
        end
`endif

        // Randomized bus traffic, including non-writes and writes to STATUS.
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 9);
            addr = 2'($urandom_range(0, 3));
            if (r < 3) begin
                cs = 1'b1; wn = 1'b0; wdata = rand_word(addr);
            end else if (r == 3) begin
                cs = 1'b0; wn = 1'b0; wdata = $urandom;
            end else if (r == 4) begin
                cs = 1'b1; wn = 1'b1; wdata = $urandom;
            end else begin
                cs = 1'b0; wn = 1'b1;
            end
            step();
        end
        cs = 1'b0; wn = 1'b1;

        // Asynchronous reset in the middle of a scroll.
        bus_write(2'd2, 32'd0);
        bus_write(2'd0, 32'h0012_3456);
        bus_write(2'd1, 32'h3);
        addr = 2'd3;
        idle(5);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) check($sformatf("async_rst_hex%0d", i), 32'(hexv[i]), 32'h7F);
        check("async_rst_status", readdata, 32'd0);
        m_reset();
        @(posedge clk);
        #2 reset_n = 1'b1;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
